tile_inst_sequencer: RTL

//  Generates the 34-bit inst word driving core, one word per clk, for one tile pass:
//  - weight fetch xmem->L0, then array load;
//  - activation fetch xmem->L0, then execute;
//  - OFIFO drain into pmem.

---
 rtl/tile_seq_pkg.sv | 32 +++
 rtl/tile_inst_sequencer_rd_align.sv | 35 +++
 rtl/tile_inst_sequencer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/tile_seq_pkg.sv
// tile_seq_pkg: shared definitions for the tile instruction sequencer.
//   - seq_state_e : pass state machine encoding
//   - B_*         : bit positions of the fields inside the 34-bit core inst word
//   - IDLE_INST   : safe word (both SRAMs disabled, no strobes)
package tile_seq_pkg;

  localparam int INST_W = 34;
  localparam int AF_W   = 11;  // width of the A_p / A_x fields in inst

  typedef enum logic [2:0] {
    IDLE, WXFER, WLOAD, WGAP, AXFER, EXEC, OREAD, DONE
  } seq_state_e;

  localparam int B_ACC      = 33;
  localparam int B_CEN_P    = 32;
  localparam int B_WEN_P    = 31;
  localparam int B_AP       = 20;  // A_p occupies [30:20]
  localparam int B_CEN_X    = 19;
  localparam int B_WEN_X    = 18;
  localparam int B_AX       = 7;   // A_x occupies [17:7]
  localparam int B_OFIFO_RD = 6;
  localparam int B_IFIFO_WR = 5;
  localparam int B_IFIFO_RD = 4;
  localparam int B_L0_RD    = 3;
  localparam int B_L0_WR    = 2;
  localparam int B_EXEC     = 1;
  localparam int B_LOAD     = 0;

  // CEN_p, WEN_p, CEN_x, WEN_x high; everything else low.
  localparam logic [INST_W-1:0] IDLE_INST = 34'h1_800C_0000;

endpackage

// File: rtl/tile_inst_sequencer_rd_align.sv
// seq_rd_align: one-cycle delay of a read strobe and its index, so the
// consumer side (L0 write, pmem write) lines up with SRAM/FIFO read data.
//   clk, reset (async, active-low), clr (sync flush)
//   in_strb/in_idx  : strobe and index issued this cycle
//   out_strb/out_idx: same, one cycle later
module seq_rd_align #(
  parameter int IW = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          in_strb,
  input  logic [IW-1:0] in_idx,
  output logic          out_strb,
  output logic [IW-1:0] out_idx
);
  logic          strb_q;
  logic [IW-1:0] idx_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      strb_q <= 1'b0;
      idx_q  <= '0;
    end else if (clr) begin
      strb_q <= 1'b0;
      idx_q  <= '0;
    end else begin
      strb_q <= in_strb;
      idx_q  <= in_idx;
    end
  end

  assign out_strb = strb_q;
  assign out_idx  = idx_q;
endmodule

// File: rtl/tile_inst_sequencer.sv
// tile_inst_sequencer: emits one 34-bit core inst word per clock for a tile
// pass: weight fetch + array load, activation fetch + execute, OFIFO drain.
// Ports:
//   clk, reset (async, active-low)
//   start, abort                 : launch (when idle) / cancel a pass
//   cfg_w_base/a_base/p_base     : SRAM bases, cfg_n_act: vectors, cfg_acc
//   ofifo_valid                  : core OFIFO has data
//   inst                         : registered core instruction word
//   busy, done, err_timeout      : status; perf_cycles: busy cycles of last pass
// Build option: SEQ_PERF_CNT_EN enables the busy-cycle counter (else perf_cycles=0).
module tile_inst_sequencer
  import tile_seq_pkg::*;
#(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 11,
  parameter int nact_bw = 11,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [addr_bw-1:0] cfg_w_base,
  input  logic [addr_bw-1:0] cfg_a_base,
  input  logic [addr_bw-1:0] cfg_p_base,
  input  logic [nact_bw-1:0] cfg_n_act,
  input  logic               cfg_acc,
  input  logic               ofifo_valid,
  output logic [INST_W-1:0]  inst,
  output logic               busy,
  output logic               done,
  output logic               err_timeout,
  output logic [31:0]        perf_cycles
);
  localparam int CW = nact_bw + 5;            // covers n_act+1 and row+col
  localparam int TW = $clog2(TIMEOUT + 1);

  seq_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [nact_bw-1:0] rd_k_q, rd_k_d;
  logic [TW-1:0]      to_q, to_d;
  logic [addr_bw-1:0] w_base_q, w_base_d, a_base_q, a_base_d, p_base_q, p_base_d;
  logic [nact_bw-1:0] n_act_q, n_act_d;
  logic               acc_q, acc_d;
  logic [INST_W-1:0]  inst_q, inst_d;
  logic               busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic               strb_d, al_strb, al_clr;
  logic [nact_bw-1:0] idx_d, al_idx;
  logic [CW-1:0]      n_ext;
  logic               start_acc;

  assign n_ext     = CW'(n_act_q);
  assign start_acc = start && (state_q == IDLE);
  assign al_clr    = abort && (state_q != IDLE);

  seq_rd_align #(.IW(nact_bw)) u_align (
    .clk(clk), .reset(reset), .clr(al_clr),
    .in_strb(strb_d), .in_idx(idx_d),
    .out_strb(al_strb), .out_idx(al_idx)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    rd_k_d   = rd_k_q;
    to_d     = to_q;
    w_base_d = w_base_q;
    a_base_d = a_base_q;
    p_base_d = p_base_q;
    n_act_d  = n_act_q;
    acc_d    = acc_q;
    err_d    = err_q;
    inst_d   = IDLE_INST;
    strb_d   = 1'b0;
    idx_d    = '0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_acc) begin
          w_base_d = cfg_w_base;
          a_base_d = cfg_a_base;
          p_base_d = cfg_p_base;
          n_act_d  = cfg_n_act;
          acc_d    = cfg_acc;
          err_d    = 1'b0;
          rd_k_d   = '0;
          state_d  = WXFER;
        end
      end
      WXFER: begin
        if (cnt_q < CW'(row)) begin
          inst_d[B_CEN_X]       = 1'b0;
          inst_d[B_AX +: AF_W]  = AF_W'(w_base_q + addr_bw'(cnt_q));
          strb_d                = 1'b1;
        end
        inst_d[B_L0_WR] = al_strb;  // data read last cycle lands in L0 now
        if (cnt_q == CW'(row)) begin
          state_d = WLOAD;
          cnt_d   = '0;
        end
      end
      WLOAD: begin
        inst_d[B_L0_RD] = 1'b1;
        inst_d[B_LOAD]  = 1'b1;
        if (cnt_q == CW'(col - 1)) begin
          state_d = WGAP;
          cnt_d   = '0;
        end
      end
      WGAP: begin
        if (cnt_q == CW'(row + col - 1)) begin
          state_d = (n_act_q == '0) ? DONE : AXFER;
          cnt_d   = '0;
        end
      end
      AXFER: begin
        if (cnt_q < n_ext) begin
          inst_d[B_CEN_X]       = 1'b0;
          inst_d[B_AX +: AF_W]  = AF_W'(a_base_q + addr_bw'(cnt_q));
          strb_d                = 1'b1;
        end
        inst_d[B_L0_WR] = al_strb;
        if (cnt_q == n_ext) begin
          state_d = EXEC;
          cnt_d   = '0;
        end
      end
      EXEC: begin
        inst_d[B_L0_RD] = 1'b1;
        inst_d[B_EXEC]  = 1'b1;
        if (cnt_q + CW'(1) == n_ext) begin
          state_d = OREAD;
          rd_k_d  = '0;
          to_d    = '0;
        end
      end
      OREAD: begin
        if (ofifo_valid && (rd_k_q < n_act_q)) begin
          inst_d[B_OFIFO_RD] = 1'b1;
          strb_d             = 1'b1;
          idx_d              = rd_k_q;
          rd_k_d             = rd_k_q + nact_bw'(1);
        end
        // Vector popped last cycle is written to pmem now.
        if (al_strb) begin
          inst_d[B_CEN_P]      = 1'b0;
          inst_d[B_WEN_P]      = 1'b0;
          inst_d[B_AP +: AF_W] = AF_W'(p_base_q + addr_bw'(al_idx));
          inst_d[B_ACC]        = acc_q;
        end
        to_d = ofifo_valid ? '0 : to_q + TW'(1);
        if (al_strb && (al_idx == n_act_q - nact_bw'(1))) begin
          state_d = DONE;
        end else if (!ofifo_valid && (to_q == TW'(TIMEOUT - 1))) begin
          state_d = IDLE;
          err_d   = 1'b1;
          inst_d  = IDLE_INST;
          strb_d  = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (al_clr) begin
      state_d = IDLE;
      inst_d  = IDLE_INST;
      strb_d  = 1'b0;
    end

    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rd_k_q   <= '0;
      to_q     <= '0;
      w_base_q <= '0;
      a_base_q <= '0;
      p_base_q <= '0;
      n_act_q  <= '0;
      acc_q    <= 1'b0;
      inst_q   <= IDLE_INST;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_k_q   <= rd_k_d;
      to_q     <= to_d;
      w_base_q <= w_base_d;
      a_base_q <= a_base_d;
      p_base_q <= p_base_d;
      n_act_q  <= n_act_d;
      acc_q    <= acc_d;
      inst_q   <= inst_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  // Counts while busy; value freezes once the pass ends.
  always_comb begin
    perf_d = perf_q;
    if (start_acc)   perf_d = '0;
    else if (busy_q) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

  assign inst        = inst_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_timeout = err_q;
endmodule
